// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - data-memory port arbiter between CPU access stage and DMA/debug
// CPU wins by default; after MAX_CPU_STREAK contended CPU wins one DMA slot is forced.
module dmem_port_arbiter #(
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  input  logic [3:0]  cpu_wr_mask,
  output logic        cpu_stall,
  output logic        cpu_rd_valid,
  output logic [31:0] cpu_rd_data,
  input  logic        dma_valid,
  input  logic        dma_wr_en,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wr_data,
  input  logic [3:0]  dma_wr_mask,
  output logic        dma_ready,
  output logic        dma_rd_valid,
  output logic [31:0] dma_rd_data,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  logic [3:0]  streak;
  logic [3:0]  streak_nxt;
  logic        cpu_grant;
  logic        dma_grant;
  logic        sel_wr_en;
  logic [31:0] sel_addr;
  logic [31:0] sel_wr_data;
  logic [3:0]  sel_wr_mask;
  logic        pend_cpu;
  logic        pend_dma;
  logic [31:0] cpu_rd_hold;
  logic [31:0] dma_rd_hold;

  // Grants are forced low while rst is high so nothing reaches the BRAM.
  always_comb begin
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    if (!rst) begin
      if (cpu_req && !(dma_valid && (streak >= STREAK_MAX))) begin
        cpu_grant = 1'b1;
      end else if (dma_valid) begin
        dma_grant = 1'b1;
      end
    end
  end

  // Streak only grows while the DMA is actually being kept waiting.
  always_comb begin
    streak_nxt = 4'd0;
    if (cpu_grant && dma_valid) begin
      if (streak >= STREAK_MAX) begin
        streak_nxt = STREAK_MAX;
      end else begin
        streak_nxt = streak + 4'd1;
      end
    end
  end

  always_comb begin
    sel_wr_en   = cpu_wr_en;
    sel_addr    = cpu_addr;
    sel_wr_data = cpu_wr_data;
    sel_wr_mask = cpu_wr_mask;
    if (dma_grant) begin
      sel_wr_en   = dma_wr_en;
      sel_addr    = dma_addr;
      sel_wr_data = dma_wr_data;
      sel_wr_mask = dma_wr_mask;
    end
  end

  assign mem_en      = cpu_grant | dma_grant;
  assign mem_we      = (mem_en && sel_wr_en) ? sel_wr_mask : 4'b0000;
  assign mem_addr    = sel_addr & 32'hFFFF_FFFC;
  assign mem_wr_data = sel_wr_data;

  assign cpu_stall = cpu_req & ~cpu_grant & ~rst;
  assign dma_ready = dma_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak      <= 4'd0;
      pend_cpu    <= 1'b0;
      pend_dma    <= 1'b0;
      cpu_rd_hold <= 32'd0;
      dma_rd_hold <= 32'd0;
    end else begin
      streak   <= streak_nxt;
      pend_cpu <= cpu_grant & ~cpu_wr_en;
      pend_dma <= dma_grant & ~dma_wr_en;
      if (pend_cpu) begin
        cpu_rd_hold <= mem_rd_data;
      end
      if (pend_dma) begin
        dma_rd_hold <= mem_rd_data;
      end
    end
  end

  // BRAM data is live only in the return cycle; the hold register keeps it afterwards.
  assign cpu_rd_valid = pend_cpu;
  assign dma_rd_valid = pend_dma;
  assign cpu_rd_data  = pend_cpu ? mem_rd_data : cpu_rd_hold;
  assign dma_rd_data  = pend_dma ? mem_rd_data : dma_rd_hold;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized and directed bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr_en;
  logic [31:0] cpu_addr, cpu_wr_data;
  logic [3:0]  cpu_wr_mask;
  logic        cpu_stall, cpu_rd_valid;
  logic [31:0] cpu_rd_data;
  logic        dma_valid, dma_wr_en;
  logic [31:0] dma_addr, dma_wr_data;
  logic [3:0]  dma_wr_mask;
  logic        dma_ready, dma_rd_valid;
  logic [31:0] dma_rd_data;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wr_data;
  logic [31:0] mem_rd_data;

  dmem_port_arbiter #(.MAX_CPU_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_mask(cpu_wr_mask),
    .cpu_stall(cpu_stall), .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .dma_valid(dma_valid), .dma_wr_en(dma_wr_en), .dma_addr(dma_addr),
    .dma_wr_data(dma_wr_data), .dma_wr_mask(dma_wr_mask),
    .dma_ready(dma_ready), .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A5A_0000 ^ 32'(i * 32'h0001_0003);
  endfunction

  // Environment BRAM: one-cycle read latency, byte-lane writes.
  logic [31:0] bram [256];
  bit          bram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!bram_loaded) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
      bram_loaded <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr[9:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
      mem_rd_data <= bram[mem_addr[9:2]];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  int          m_streak;
  int          m_pend;       // 0 none, 1 cpu, 2 dma
  logic [31:0] m_pend_data;
  logic [31:0] m_cpu_last, m_dma_last;
  bit          cpu_known, dma_known;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_streak  = 0;
    m_pend    = 0;
    cpu_known = 0;
    dma_known = 0;
  endtask

  task automatic step(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                      input logic [31:0] c_data, input logic [3:0] c_mask,
                      input logic d_v, input logic d_we, input logic [31:0] d_addr,
                      input logic [31:0] d_data, input logic [3:0] d_mask,
                      output logic cg, output logic dg);
    logic        exp_cg, exp_dg, g_we;
    logic [31:0] g_addr, g_data;
    logic [3:0]  g_mask;
    @(negedge clk);
    cpu_req = c_req; cpu_wr_en = c_we; cpu_addr = c_addr; cpu_wr_data = c_data; cpu_wr_mask = c_mask;
    dma_valid = d_v; dma_wr_en = d_we; dma_addr = d_addr; dma_wr_data = d_data; dma_wr_mask = d_mask;
    exp_cg = c_req && !(d_v && m_streak == MAXS);
    exp_dg = d_v && !exp_cg;
    g_we   = exp_dg ? d_we : c_we;
    g_addr = (exp_dg ? d_addr : c_addr) & 32'hFFFF_FFFC;
    g_data = exp_dg ? d_data : c_data;
    g_mask = exp_dg ? d_mask : c_mask;
    #3;
    chk("cpu_stall", 32'(cpu_stall), 32'(c_req && !exp_cg));
    chk("dma_ready", 32'(dma_ready), 32'(exp_dg));
    chk("mem_en", 32'(mem_en), 32'(exp_cg || exp_dg));
    chk("mem_we", 32'(mem_we), 32'(((exp_cg || exp_dg) && g_we) ? g_mask : 4'b0));
    if (exp_cg || exp_dg) begin
      chk("mem_addr", mem_addr, g_addr);
      chk("mem_wr_data", mem_wr_data, g_data);
    end
    chk("cpu_rd_valid", 32'(cpu_rd_valid), 32'(m_pend == 1));
    chk("dma_rd_valid", 32'(dma_rd_valid), 32'(m_pend == 2));
    if (m_pend == 1) begin
      m_cpu_last = m_pend_data; cpu_known = 1;
    end
    if (m_pend == 2) begin
      m_dma_last = m_pend_data; dma_known = 1;
    end
    if (cpu_known) chk("cpu_rd_data", cpu_rd_data, m_cpu_last);
    if (dma_known) chk("dma_rd_data", dma_rd_data, m_dma_last);
    // Advance the model to the state after this clock edge.
    m_streak    = (c_req && d_v && exp_cg) ? m_streak + 1 : 0;
    m_pend      = (exp_cg && !c_we) ? 1 : (exp_dg && !d_we) ? 2 : 0;
    m_pend_data = ref_mem[g_addr[9:2]];
    if ((exp_cg || exp_dg) && g_we)
      for (int b = 0; b < 4; b++)
        if (g_mask[b]) ref_mem[g_addr[9:2]][8*b +: 8] = g_data[8*b +: 8];
    cg = exp_cg;
    dg = exp_dg;
  endtask

  task automatic idle();
    logic cg, dg;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, dg);
  endtask

  logic        cg, dg;
  logic        dv, dwe;
  logic [31:0] da, dd;
  logic [3:0]  dm;
  int          dma_wins;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    rst = 1'b1;
    cpu_req = 1; cpu_wr_en = 0; cpu_addr = 32'h40; cpu_wr_data = 0; cpu_wr_mask = 0;
    dma_valid = 1; dma_wr_en = 1; dma_addr = 32'h80; dma_wr_data = 0; dma_wr_mask = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cpu_stall", 32'(cpu_stall), 0);
    chk("rst_dma_ready", 32'(dma_ready), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_cpu_rd_valid", 32'(cpu_rd_valid), 0);
    chk("rst_dma_rd_valid", 32'(dma_rd_valid), 0);
    cpu_req = 0; dma_valid = 0;
    @(negedge clk);
    rst = 1'b0;

    // Single-requester accesses, including the documented sample values.
    step(0, 0, 0, 0, 0, 1, 1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, cg, dg);
    step(1, 0, 32'h0000_1006, 0, 0, 0, 0, 0, 0, 0, cg, dg);
    chk("cpu_read_granted", 32'(cg), 1);
    step(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678, 4'b0011, cg, dg);
    chk("dma_write_granted", 32'(dg), 1);
    idle();

    // Alternating-owner reads back to back.
    step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, cg, dg);
    step(0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 0, cg, dg);
    step(1, 0, 32'h104, 0, 0, 0, 0, 0, 0, 0, cg, dg);
    idle();

    // Ten contended cycles: DMA wins only the 5th and 10th.
    dma_wins = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 32'h300 + 32'(i * 4), 0, 0, 1, 0, 32'h380 + 32'(i * 4), 0, 0, cg, dg);
      chk("contend_seq", 32'(dg), 32'(i == 4 || i == 9));
      dma_wins += int'(dg);
    end
    chk("contend_dma_wins", 32'(dma_wins), 2);
    idle();

    // Streak at 3, DMA drops for a cycle, then a full fresh streak is needed.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h10, 0, 0, 1, 0, 32'h14, 0, 0, cg, dg);
    step(1, 0, 32'h10, 0, 0, 0, 0, 32'h14, 0, 0, cg, dg);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 32'h18, 0, 0, 1, 0, 32'h1C, 0, 0, cg, dg);
      chk("streak_restart", 32'(dg), 32'(i == 4));
    end
    idle();

    // Reset asserted mid-cycle right after a granted CPU read.
    step(1, 0, 32'h44, 0, 0, 1, 0, 32'h48, 0, 0, cg, dg);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cpu_rd_valid", 32'(cpu_rd_valid), 0);
    chk("mid_rst_mem_en", 32'(mem_en), 0);
    chk("mid_rst_cpu_stall", 32'(cpu_stall), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_cpu_rd_valid_edge", 32'(cpu_rd_valid), 0);
    chk("mid_rst_dma_ready", 32'(dma_ready), 0);
    cpu_req = 0; dma_valid = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int i = 0; i < MAXS; i++) begin
      step(1, 1, 32'h50, 32'hCAFE_0000 + 32'(i), 4'hF, 1, 0, 32'h54, 0, 0, cg, dg);
      chk("post_rst_streak_cpu", 32'(cg), 1);
    end
    step(1, 0, 32'h50, 0, 0, 1, 0, 32'h54, 0, 0, cg, dg);
    chk("post_rst_streak_dma", 32'(dg), 1);

    // Randomized traffic; DMA holds its request until accepted.
    dv = 0; dwe = 0; da = 0; dd = 0; dm = 0; dg = 0;
    for (int n = 0; n < 800; n++) begin
      logic c_req, c_we;
      if (!dv || dg) begin
        dv  = ($urandom_range(0, 2) != 0);
        dwe = $urandom_range(0, 1) != 0;
        da  = $urandom;
        dd  = $urandom;
        dm  = 4'($urandom);
      end
      c_req = ($urandom_range(0, 3) != 0);
      c_we  = $urandom_range(0, 1) != 0;
      step(c_req, c_we, $urandom, $urandom, 4'($urandom), dv, dwe, da, dd, dm, cg, dg);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single synchronous data-memory port between the core's memory-access stage (CPU) and a DMA/debug requester.
- Grants at most one access per cycle and stalls the CPU pipeline when it loses arbitration.
- Steers the one-cycle-latency read data back to the owner of each read.
- Sits between the memory-access stage and the data BRAM; the CPU always gets priority except when the anti-starvation limit forces a DMA slot.

Parameters:
MAX_CPU_STREAK, 4, consecutive CPU grants allowed while DMA is waiting before one DMA grant is forced (1..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cpu_req  input  1  CPU access request this cycle (read or write)
cpu_wr_en  input  1  1 = write, 0 = read
cpu_addr  input  32  byte address; bits [1:0] ignored
cpu_wr_data  input  32  write data, already lane-aligned
cpu_wr_mask  input  4  byte-lane write enables
cpu_stall  output  1  CPU request not granted this cycle; pipeline must hold
cpu_rd_valid  output  1  cpu_rd_data valid (cycle after granted CPU read)
cpu_rd_data  output  32  read data to CPU
dma_valid  input  1  DMA request valid; held with fields stable until accepted
dma_wr_en  input  1  1 = write, 0 = read
dma_addr  input  32  byte address; bits [1:0] ignored
dma_wr_data  input  32  write data
dma_wr_mask  input  4  byte-lane write enables
dma_ready  output  1  DMA request accepted this cycle (valid & ready = transfer)
dma_rd_valid  output  1  dma_rd_data valid
dma_rd_data  output  32  read data to DMA
mem_en  output  1  memory access enable
mem_we  output  4  byte write enables to memory (0 for reads)
mem_addr  output  32  word address to memory, bits [1:0] forced 0
mem_wr_data  output  32  write data to memory
mem_rd_data  input  32  memory read data, valid one cycle after a read enable

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - streak counter = 0, pending-read owner = none, cpu_rd_valid = dma_rd_valid = 0.
  - While rst is high, all combinational outputs are forced to 0: cpu_stall, dma_ready, mem_en, mem_we.
- Arbitration is combinational each cycle; outputs depend on the current requests and the registered streak state.
  - Only cpu_req: CPU granted, cpu_stall = 0, dma_ready = 0.
  - Only dma_valid: DMA granted, dma_ready = 1.
  - Both, streak < MAX_CPU_STREAK: CPU granted, dma_ready = 0, streak += 1.
  - Both, streak == MAX_CPU_STREAK: DMA granted, cpu_stall = 1, streak cleared to 0.
  - DMA granted (any case): streak cleared to 0.
  - dma_valid low: streak cleared to 0, even if the CPU is granted.
  - Neither: mem_en = 0, streak cleared to 0.
- Memory port fields:
  - mem_en = 1 for any grant; mem_addr = granted addr & 32'hFFFFFFFC.
  - mem_we = granted mask if write, else 4'b0; mem_wr_data = granted write data.
- cpu_stall = cpu_req & ~cpu_grant. A stalled CPU re-presents the same request next cycle; no request is stored inside this block.
- Read return:
  - On a granted read, register the owner (CPU or DMA).
  - Next cycle, drive the owner's rd_valid = 1 and route mem_rd_data to the owner's rd_data.
  - The non-owner's rd_data holds its last value; its rd_valid = 0.
  - Writes produce no rd_valid. Back-to-back reads from alternating owners must return correctly every cycle.
- Latency:
  - Grant is 0 cycles (same cycle as request).
  - Read data returns 1 cycle after grant.
  - Maximum CPU stall from arbitration is 1 cycle per MAX_CPU_STREAK+1 contended cycles.
- Streak counter: 4 bits, saturates at MAX_CPU_STREAK, never wraps.
- Reset asserted mid-read: the pending return is dropped; no rd_valid is issued after reset deasserts.
- DMA holds dma_valid with stable fields until dma_ready; this block does not check that rule.

Test Plan:
- CPU read alone, cpu_addr=0x0000_1006: mem_en=1, mem_addr=0x0000_1004, mem_we=0, cpu_stall=0. Next cycle cpu_rd_valid=1, cpu_rd_data=mem_rd_data (e.g. 0xDEADBEEF), dma_rd_valid=0.
- DMA write alone, dma_addr=0x20, dma_wr_mask=4'b0011, dma_wr_data=0x1234_5678: dma_ready=1, mem_we=4'b0011, mem_addr=0x20, mem_wr_data=0x1234_5678.
- cpu_req and dma_valid both held high for 10 cycles, MAX_CPU_STREAK=4: grant sequence C,C,C,C,D,C,C,C,C,D. cpu_stall=1 only in cycles 5 and 10, dma_ready=1 only in cycles 5 and 10.
- Alternating reads: CPU read 0x100 granted in cycle n, DMA read 0x200 in n+1 (cpu_req low). Cycle n+1: cpu_rd_valid=1 with data for 0x100. Cycle n+2: dma_rd_valid=1 with data for 0x200. Never both valid at once.
- Assert rst asynchronously mid-cycle after a granted CPU read: cpu_rd_valid=0 immediately and on the following edges, streak=0, mem_en=0 while rst is high.
- Contended cycles with streak at 3, then dma_valid dropped for one cycle: streak resets to 0, and the next contention needs 4 further CPU grants before the DMA slot.
